// File: rtl/word_alu_pkg.sv
// rtl/word_alu_pkg.sv - op codes, FSM states and Z8 flag bit indices for the word ALU.
package word_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
    OP_CP   = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_INC  = 4'd8,  OP_DEC = 4'd9,  OP_RLC = 4'd10, OP_RL  = 4'd11,
    OP_RRC  = 4'd12, OP_RR  = 4'd13, OP_SRA = 4'd14, OP_DADD = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Same bit positions as the byte ALU's flag register.
  localparam int FLAG_C = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 5;
  localparam int FLAG_V = 4;
  localparam int FLAG_D = 3;
  localparam int FLAG_H = 2;

  function automatic logic msb_first(input logic [3:0] op);
    return (op == OP_RRC) || (op == OP_RR) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/word_alu_slice.sv
// rtl/word_alu_slice.sv - combinational 8-bit datapath shared across all bytes of a word op.
// WORD_ALU_DADD_EN enables the packed-BCD add on op 15; otherwise op 15 passes a through.
module word_alu_slice
  import word_alu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  input  logic [3:0] op_i,
  output logic [7:0] out_o,
  output logic       c_o,
  output logic       h_o,
  output logic       z_o,
  output logic       v_o
);

  logic [7:0] bb;
  logic [8:0] sum9;
  logic [8:0] dif9;
`ifdef WORD_ALU_DADD_EN
  logic [4:0] lo5;
  logic [4:0] hi5;
  logic       nib_c;
`endif

  always_comb begin
    // INC/DEC reuse the add/subtract path with a zero operand and the chain carry.
    bb    = ((op_i == OP_INC) || (op_i == OP_DEC)) ? 8'h00 : b_i;
    sum9  = {1'b0, a_i} + {1'b0, bb} + {8'b0, c_i};
    dif9  = {1'b0, a_i} - {1'b0, bb} - {8'b0, c_i};
    out_o = a_i;
    c_o   = c_i;
    h_o   = 1'b0;
    v_o   = 1'b0;
`ifdef WORD_ALU_DADD_EN
    lo5   = 5'd0;
    hi5   = 5'd0;
    nib_c = 1'b0;
`endif
    case (op_i)
      OP_ADD, OP_ADC, OP_INC: begin
        out_o = sum9[7:0];
        c_o   = sum9[8];
        h_o   = ({1'b0, a_i[3:0]} + {1'b0, bb[3:0]} + {4'b0, c_i}) > 5'd15;
        v_o   = (a_i[7] == bb[7]) && (sum9[7] != a_i[7]);
      end
      OP_SUB, OP_SBC, OP_CP, OP_DEC: begin
        out_o = dif9[7:0];
        c_o   = dif9[8];
        h_o   = {1'b0, a_i[3:0]} < ({1'b0, bb[3:0]} + {4'b0, c_i});
        v_o   = (a_i[7] != bb[7]) && (dif9[7] != a_i[7]);
      end
      OP_AND: out_o = a_i & b_i;
      OP_OR:  out_o = a_i | b_i;
      OP_XOR: out_o = a_i ^ b_i;
      OP_RLC, OP_RL: begin
        out_o = {a_i[6:0], c_i};
        c_o   = a_i[7];
      end
      OP_RRC, OP_RR, OP_SRA: begin
        out_o = {c_i, a_i[7:1]};
        c_o   = a_i[0];
      end
      OP_DADD: begin
`ifdef WORD_ALU_DADD_EN
        lo5 = {1'b0, a_i[3:0]} + {1'b0, bb[3:0]} + {4'b0, c_i};
        if (lo5 > 5'd9) begin
          lo5   = lo5 + 5'd6;
          nib_c = 1'b1;
        end
        hi5 = {1'b0, a_i[7:4]} + {1'b0, bb[7:4]} + {4'b0, nib_c};
        c_o = hi5 > 5'd9;
        if (c_o) hi5 = hi5 + 5'd6;
        out_o = {hi5[3:0], lo5[3:0]};
        h_o   = nib_c;
`else
        out_o = a_i;
`endif
      end
      default: ;
    endcase
    z_o = (out_o == 8'h00);
  end

endmodule

// File: rtl/word_alu.sv
// rtl/word_alu.sv - byte-serial N-byte ALU with start/busy/done handshake and registered outputs.
// WORD_ALU_DADD_EN selects BCD add for op 15; otherwise op 15 returns a and flags_in unchanged.
module word_alu
  import word_alu_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [3:0]           op_i,
  input  logic [8*BYTES-1:0]   a_i,
  input  logic [8*BYTES-1:0]   b_i,
  input  logic [7:0]           flags_in_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [8*BYTES-1:0]   result_o,
  output logic [7:0]           flags_out_o
);

  localparam int W  = 8 * BYTES;
  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

  state_e          state_q, state_d;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q, b_q, w_q, w_d, result_q;
  logic [7:0]      fin_q, flags_q, flags_d;
  logic            c_q, h_q, z_q, c_init;
  logic [KW-1:0]   k_q, idx;
  logic            msb, last, h_now, z_now;
  logic [7:0]      a_byte, b_byte, s_out;
  logic            s_c, s_h, s_z, s_v;

  assign msb    = msb_first(op_q);
  assign idx    = msb ? (K_LAST - k_q) : k_q;
  assign last   = (k_q == K_LAST);
  assign a_byte = a_q[8*int'(idx) +: 8];
  assign b_byte = b_q[8*int'(idx) +: 8];

  word_alu_slice u_slice (
    .a_i   (a_byte),
    .b_i   (b_byte),
    .c_i   (c_q),
    .op_i  (op_q),
    .out_o (s_out),
    .c_o   (s_c),
    .h_o   (s_h),
    .z_o   (s_z),
    .v_o   (s_v)
  );

  always_comb begin
    c_init = 1'b0;
    case (op_i)
      OP_ADC, OP_SBC, OP_RLC, OP_RRC: c_init = flags_in_i[FLAG_C];
      OP_INC, OP_DEC:                 c_init = 1'b1;
      OP_RL, OP_SRA:                  c_init = a_i[W-1];
      OP_RR:                          c_init = a_i[0];
      default:                        c_init = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_d = w_q;
    // CP only reports flags; the word written back is operand A.
    w_d[8*int'(idx) +: 8] = (op_q == OP_CP) ? a_byte : s_out;
    h_now   = (k_q == '0) ? s_h : h_q;
    z_now   = z_q & s_z;
    flags_d = fin_q;
    flags_d[FLAG_Z] = z_now;
    flags_d[FLAG_S] = msb ? w_d[W-1] : s_out[7];
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
        flags_d[FLAG_C] = s_c;
        flags_d[FLAG_V] = s_v;
        flags_d[FLAG_H] = h_now;
        if (op_q != OP_CP) flags_d[FLAG_D] = (op_q == OP_SUB) || (op_q == OP_SBC);
      end
      OP_AND, OP_OR, OP_XOR: flags_d[FLAG_V] = 1'b0;
      OP_INC, OP_DEC:        flags_d[FLAG_V] = s_v;
      OP_RLC, OP_RL, OP_RRC, OP_RR, OP_SRA: flags_d[FLAG_C] = s_c;
      OP_DADD: begin
`ifdef WORD_ALU_DADD_EN
        flags_d[FLAG_C] = s_c;
        flags_d[FLAG_H] = h_now;
        flags_d[FLAG_D] = 1'b0;
`else
        flags_d = fin_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      op_q     <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      w_q      <= '0;
      fin_q    <= 8'h00;
      c_q      <= 1'b0;
      h_q      <= 1'b0;
      z_q      <= 1'b1;
      k_q      <= '0;
      result_q <= '0;
      flags_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start_i) begin
          op_q  <= op_i;
          a_q   <= a_i;
          b_q   <= b_i;
          fin_q <= flags_in_i;
          c_q   <= c_init;
          h_q   <= 1'b0;
          z_q   <= 1'b1;
          k_q   <= '0;
          w_q   <= '0;
        end
        S_RUN: begin
          w_q <= w_d;
          c_q <= s_c;
          z_q <= z_now;
          if (k_q == '0) h_q <= s_h;
          k_q <= k_q + 1'b1;
          if (last) begin
            result_q <= w_d;
            flags_q  <= flags_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign result_o    = result_q;
  assign flags_out_o = flags_q;

endmodule

// File: tb/tb_word_alu.sv
// tb/tb_word_alu.sv - self-checking bench for word_alu (BYTES=2) against a whole-word reference model.
// Honours WORD_ALU_DADD_EN the same way as the design.
module tb_word_alu;

  localparam int BYTES = 2;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [7:0]   fin;
  logic         busy, done;
  logic [W-1:0] result;
  logic [7:0]   fout;

  int total = 0;
  int bad   = 0;

  word_alu #(.BYTES(BYTES)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .flags_in_i  (fin),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .flags_out_o (fout)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic; flag bits C=7 Z=6 S=5 V=4 D=3 H=2.
  function automatic void model(input logic [3:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                                input logic [7:0] mf, output logic [15:0] r, output logic [7:0] f);
    int t, sa, sb, ci, s, c;
    logic [15:0] zv;
    logic cin, setzs;
    cin = mf[7]; f = mf; r = ma; zv = ma; setzs = 1'b1;
    sa = $signed(ma); sb = $signed(mb); t = 0; s = 0; c = 0;
    ci = ((mop == 4'd1) || (mop == 4'd3)) ? int'(cin) : 0;
    case (mop)
      4'd0, 4'd1: begin
        t = int'(ma) + int'(mb) + ci; r = t[15:0]; zv = r;
        f[7] = t[16];
        f[2] = (int'(ma[3:0]) + int'(mb[3:0]) + ci) > 15;
        f[4] = (sa + sb + ci > 32767) || (sa + sb + ci < -32768);
        f[3] = 1'b0;
      end
      4'd2, 4'd3, 4'd4: begin
        t = int'(ma) - int'(mb) - ci; zv = t[15:0];
        r = (mop == 4'd4) ? ma : t[15:0];
        f[7] = (t < 0);
        f[2] = int'(ma[3:0]) < (int'(mb[3:0]) + ci);
        f[4] = (sa - sb - ci > 32767) || (sa - sb - ci < -32768);
        if (mop != 4'd4) f[3] = 1'b1;
      end
      4'd5: begin r = ma & mb; zv = r; f[4] = 1'b0; end
      4'd6: begin r = ma | mb; zv = r; f[4] = 1'b0; end
      4'd7: begin r = ma ^ mb; zv = r; f[4] = 1'b0; end
      4'd8: begin r = ma + 16'd1; zv = r; f[4] = (ma == 16'h7FFF); end
      4'd9: begin r = ma - 16'd1; zv = r; f[4] = (ma == 16'h8000); end
      4'd10: begin r = {ma[14:0], cin};    zv = r; f[7] = ma[15]; end
      4'd11: begin r = {ma[14:0], ma[15]}; zv = r; f[7] = ma[15]; end
      4'd12: begin r = {cin, ma[15:1]};    zv = r; f[7] = ma[0]; end
      4'd13: begin r = {ma[0], ma[15:1]};  zv = r; f[7] = ma[0]; end
      4'd14: begin r = {ma[15], ma[15:1]}; zv = r; f[7] = ma[0]; end
      default: begin
`ifdef WORD_ALU_DADD_EN
        for (int d = 0; d < 4; d++) begin
          s = int'(ma[4*d +: 4]) + int'(mb[4*d +: 4]) + c;
          if (s > 9) begin s = s + 6; c = 1; end else c = 0;
          r[4*d +: 4] = s[3:0];
          if (d == 0) f[2] = (c != 0);
        end
        zv = r; f[7] = (c != 0); f[3] = 1'b0;
`else
        setzs = 1'b0;
`endif
      end
    endcase
    if (setzs) begin
      f[6] = (zv == 16'h0000);
      f[5] = zv[15];
    end
  endfunction

  task automatic issue(input logic [3:0] iop, input logic [15:0] ia, input logic [15:0] ib, input logic [7:0] ifl);
    @(posedge clk); #1;
    op = iop; a = ia; b = ib; fin = ifl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the observed word, flags and cycle of done (1 = cycle right after the start edge), -1 on timeout.
  task automatic do_op(input logic [3:0] iop, input logic [15:0] ia, input logic [15:0] ib, input logic [7:0] ifl,
                       output logic [15:0] r, output logic [7:0] f, output int lat);
    issue(iop, ia, ib, ifl);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; f = fout;
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; fin = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 16'h0)  begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (fout !== 8'h00)    begin bad++; $display("FAIL reset_flags got=%h want=00", fout); end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [3:0]  t_op [8];
    logic [15:0] t_a [8], t_b [8], t_res [8];
    logic [7:0]  t_fl [8], t_mask [8], t_val [8];
    logic [15:0] r;
    logic [7:0]  f;
    int lat;
    t_op[0]=4'd0;  t_a[0]=16'h00FF; t_b[0]=16'h0001; t_fl[0]=8'h00; t_res[0]=16'h0100; t_mask[0]=8'hFC; t_val[0]=8'h04;
    t_op[1]=4'd2;  t_a[1]=16'h0000; t_b[1]=16'h0001; t_fl[1]=8'h00; t_res[1]=16'hFFFF; t_mask[1]=8'hF8; t_val[1]=8'hA8;
    t_op[2]=4'd4;  t_a[2]=16'h0000; t_b[2]=16'h0001; t_fl[2]=8'h00; t_res[2]=16'h0000; t_mask[2]=8'hF8; t_val[2]=8'hA0;
    t_op[3]=4'd8;  t_a[3]=16'h7FFF; t_b[3]=16'h0000; t_fl[3]=8'h80; t_res[3]=16'h8000; t_mask[3]=8'hF0; t_val[3]=8'hB0;
    t_op[4]=4'd9;  t_a[4]=16'h0001; t_b[4]=16'h0000; t_fl[4]=8'h00; t_res[4]=16'h0000; t_mask[4]=8'h40; t_val[4]=8'h40;
    t_op[5]=4'd12; t_a[5]=16'h0001; t_b[5]=16'h0000; t_fl[5]=8'h00; t_res[5]=16'h0000; t_mask[5]=8'hC0; t_val[5]=8'hC0;
    t_op[6]=4'd11; t_a[6]=16'h8001; t_b[6]=16'h0000; t_fl[6]=8'h00; t_res[6]=16'h0003; t_mask[6]=8'h80; t_val[6]=8'h80;
`ifdef WORD_ALU_DADD_EN
    t_op[7]=4'd15; t_a[7]=16'h0999; t_b[7]=16'h0001; t_fl[7]=8'h55; t_res[7]=16'h1000; t_mask[7]=8'hC0; t_val[7]=8'h00;
`else
    t_op[7]=4'd15; t_a[7]=16'h0999; t_b[7]=16'h0001; t_fl[7]=8'h55; t_res[7]=16'h0999; t_mask[7]=8'hFF; t_val[7]=8'h55;
`endif
    for (int i = 0; i < 8; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], t_fl[i], r, f, lat);
      total++; if (lat != BYTES + 1) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, BYTES + 1); end
      total++; if (r !== t_res[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, r, t_res[i]); end
      total++; if ((f & t_mask[i]) !== t_val[i]) begin bad++; $display("FAIL dir%0d_flags got=%h want=%h mask=%h", i, f & t_mask[i], t_val[i], t_mask[i]); end
    end
  endtask

  task automatic test_random;
    logic [3:0]  rop;
    logic [15:0] ra, rb, r, er;
    logic [7:0]  rf, f, ef;
    int lat;
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rf  = 8'($urandom);
      if (i % 8 == 0) ra = 16'h0000;
      if (i % 8 == 1) ra = 16'hFFFF;
      if (i % 8 == 2) ra = 16'h7FFF;
      do_op(rop, ra, rb, rf, r, f, lat);
      model(rop, ra, rb, rf, er, ef);
      total++; if (lat != BYTES + 1) begin bad++; $display("FAIL rnd_latency op=%0d got=%0d want=%0d", rop, lat, BYTES + 1); end
      total++; if (r !== er) begin bad++; $display("FAIL rnd_result op=%0d a=%h b=%h fl=%h got=%h want=%h", rop, ra, rb, rf, r, er); end
      total++; if (f !== ef) begin bad++; $display("FAIL rnd_flags op=%0d a=%h b=%h fl=%h got=%h want=%h", rop, ra, rb, rf, f, ef); end
    end
  endtask

  task automatic test_busy_ignore;
    int dones;
    logic [15:0] r;
    dones = 0; r = 16'h0;
    issue(4'd0, 16'h1234, 16'h1111, 8'h00);
    op = 4'd2; a = 16'h0000; b = 16'hFFFF; start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) begin
        dones++;
        r = result;
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (dones != 1) begin bad++; $display("FAIL busy_ignore_dones got=%0d want=1", dones); end
    total++; if (r !== 16'h2345) begin bad++; $display("FAIL busy_ignore_result got=%h want=2345", r); end
  endtask

  task automatic test_reset_abort;
    int dones;
    dones = 0;
    issue(4'd0, 16'h0101, 16'h0101, 8'h00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (result !== 16'h0) begin bad++; $display("FAIL abort_result got=%h want=0000", result); end
    total++; if (fout !== 8'h00)   begin bad++; $display("FAIL abort_flags got=%h want=00", fout); end
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", dones); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  bop;
    logic [15:0] ba, bb, r, er;
    logic [7:0]  bf, f, ef;
    int lat;
    for (int i = 0; i < 4; i++) begin
      bop = 4'($urandom_range(0, 14));
      ba  = 16'($urandom);
      bb  = 16'($urandom);
      bf  = 8'($urandom);
      do_op(bop, ba, bb, bf, r, f, lat);
      model(bop, ba, bb, bf, er, ef);
      total++; if (lat != BYTES + 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, BYTES + 1); end
      total++; if (r !== er) begin bad++; $display("FAIL b2b_result op=%0d got=%h want=%h", bop, r, er); end
      total++; if (f !== ef) begin bad++; $display("FAIL b2b_flags op=%0d got=%h want=%h", bop, f, ef); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_busy_ignore;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
